adc_acq_ctrl: RTL
=================

# adc_acq_ctrl

Acquisition sequencer for the ADC sample path. It arms on a host command and waits for an optional level trigger. It then writes a frame of DEPTH consecutive ADC samples into the sample RAM and kicks the UART readout block. After that it waits for the readout to finish, applies a programmable hold-off, and re-arms in continuous mode. It owns the RAM write port and is the only source of the readout start strobe.

## Interface
Parameters:
- DEPTH, 200, samples per frame (RAM addresses 0..DEPTH-1)
- AW, 8, RAM address width
- DW, 8, sample width
- KICK_CYC, 4, cycles read_start is held high before its falling edge
- TIMEOUT, 1024, max cycles to wait for read_busy to rise after the kick

Ports:
- clk  in  1  single system clock
- reset_n  in  1  asynchronous, active-low reset
- adc_data  in  DW  ADC sample
- adc_valid  in  1  one-cycle strobe, adc_data valid
- run  in  1  level; continuous acquisition while high
- single  in  1  one-cycle pulse; acquire one frame
- trig_en  in  1  1 = wait for rising level crossing, 0 = free-run
- trig_level  in  DW  trigger threshold, unsigned
- holdoff  in  16  idle cycles between frame end and re-arm
- read_busy  in  1  busy from UART readout block
- ram_we  out  1  sample RAM write enable
- ram_wr_addr  out  AW  sample RAM write address
- ram_wr_data  out  DW  sample RAM write data
- read_start  out  1  readout start; readout begins on its falling edge
- acq_busy  out  1  high in every state except IDLE
- frame_cnt  out  16  completed frames, wraps at 0xFFFF->0
- timeout_err  out  1  sticky; set on readout timeout, cleared by single or run rising edge

## Operation
- States: IDLE, ARM, CAPTURE, KICK, WAIT_RISE, WAIT_DONE, HOLDOFF.
- IDLE -> ARM on single pulse or run rising edge. If both arrive in the same cycle, run wins and the mode is continuous.
- ARM:
  - trig_en=0: the first adc_valid moves to CAPTURE, and that sample is written to address 0.
  - trig_en=1: the block keeps the previous valid sample (prev, reset 0). It triggers when prev < trig_level and adc_data >= trig_level on an adc_valid. The triggering sample goes to address 0.
  - The first valid after entering ARM only loads prev. It never triggers.
- CAPTURE: each adc_valid writes to the next address. After the write to DEPTH-1, the address returns to 0 and the state moves to KICK. Samples outside CAPTURE are never written.
- KICK: read_start is high for KICK_CYC cycles, then drops and the state moves to WAIT_RISE.
- WAIT_RISE:
  - read_busy=1 moves to WAIT_DONE.
  - After TIMEOUT cycles without read_busy: set timeout_err, skip frame_cnt, go to HOLDOFF.
- WAIT_DONE: read_busy=0 increments frame_cnt and moves to HOLDOFF.
- HOLDOFF: counts holdoff cycles (0 means a single pass-through cycle). It then goes to ARM if run=1, else to IDLE.
- Single-shot mode completes one frame and then returns to IDLE.
- run falling mid-frame: the current frame completes through HOLDOFF, then the block goes to IDLE. It does not abort.
- single while acq_busy=1 is ignored.
- Reset mid-operation:
  - All state is cleared immediately and the block returns to IDLE with the RAM write port idle.
  - A partially written frame is discarded.
  - read_start drops without a readout being considered started.

## Timing
- Reset values: ram_we=0, ram_wr_addr=0, ram_wr_data=0, read_start=0, acq_busy=0, frame_cnt=0, timeout_err=0, state IDLE.
- All outputs are registered.
- ram_we, ram_wr_addr and ram_wr_data appear together, 1 cycle after the accepting adc_valid.
- The last write (addr DEPTH-1) coincides with the first cycle of read_start=1.
- read_start is high for exactly KICK_CYC consecutive cycles.
- acq_busy rises 1 cycle after the start command and falls 1 cycle after the HOLDOFF -> IDLE transition.
- Back-to-back adc_valid (every cycle) is supported. Frame write time is DEPTH valid strobes.

## Structure
- Shared package: the state encoding (3-bit enum) and default constants (DEPTH, KICK_CYC, TIMEOUT, frame header 0xA0 and terminators 0x0D/0x0A already used by the readout block).
- One sub-module, adc_trig_detect: holds prev, its first-sample qualifier, and the crossing compare; outputs a one-cycle trig_hit.
- The FSM, address counter, kick/timeout/hold-off counter (one shared 16-bit down-counter) and frame counter live in the top module.

## Test plan
- **Free-run single shot:** trig_en=0, single pulse, adc_valid every cycle with data=addr -> 200 writes with addr 0..199 and data 0..199, read_start high for 4 cycles. Readout model holds read_busy for 1000 cycles, then frame_cnt=1 and the block returns to IDLE.
- **Trigger:** trig_en=1, level=0x80, ramp 0x70..0x90 step 1 -> first write is data 0x80 at addr 0, and no write occurs before it.
- **Continuous:**
  - run=1, holdoff=50 -> between readout done and the next ARM, exactly 50 cycles pass with no writes.
  - Drop run during the third CAPTURE -> frame 3 completes, frame_cnt=3, then IDLE.
- **Timeout:** read_busy tied 0 -> after 1024 cycles in WAIT_RISE, timeout_err=1 and frame_cnt unchanged. A later single clears timeout_err.
- **Reset mid-capture:** reset_n low at addr 100 -> all outputs take reset values asynchronously. After release the state is IDLE and no writes occur until single.
- **Edge cases:**
  - single and run rise in the same cycle -> continuous mode.
  - frame_cnt preset near 0xFFFF wraps to 0.

Source files
------------

// File: rtl/adc_acq_ctrl_pkg.sv
// Shared definitions for the ADC acquisition path: sequencer state encoding
// and the default frame geometry / readout framing bytes.
package adc_acq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_KICK      = 3'd3,
        ST_WAIT_RISE = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_HOLDOFF   = 3'd6
    } acq_state_t;

    localparam int DEF_DEPTH    = 200;
    localparam int DEF_KICK_CYC = 4;
    localparam int DEF_TIMEOUT  = 1024;

    // Framing bytes emitted by the UART readout block around each frame.
    localparam logic [7:0] FRAME_HDR = 8'hA0;
    localparam logic [7:0] FRAME_CR  = 8'h0D;
    localparam logic [7:0] FRAME_LF  = 8'h0A;

endpackage

// File: rtl/adc_acq_ctrl_trig.sv
// Level-crossing trigger: remembers the previous valid sample and flags a
// rising crossing of trig_level, never on the first sample seen while armed.
module adc_trig_detect #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          arm,
    input  logic          adc_valid,
    input  logic [DW-1:0] adc_data,
    input  logic [DW-1:0] trig_level,
    output logic          trig_hit
);

    logic [DW-1:0] prev;
    logic          qual;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
            qual <= 1'b0;
        end else begin
            if (adc_valid)
                prev <= adc_data;
            // qual marks that prev holds a sample taken during this arming
            if (!arm)
                qual <= 1'b0;
            else if (adc_valid)
                qual <= 1'b1;
        end
    end

    assign trig_hit = arm && qual && adc_valid &&
                      (prev < trig_level) && (adc_data >= trig_level);

endmodule

// File: rtl/adc_acq_ctrl.sv
// Acquisition sequencer: arm, optional trigger, write one DEPTH-sample frame
// to RAM, kick the UART readout, wait for it, hold off, re-arm if continuous.
module adc_acq_ctrl
    import adc_acq_ctrl_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int KICK_CYC = DEF_KICK_CYC,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] adc_data,
    input  logic          adc_valid,
    input  logic          run,
    input  logic          single,
    input  logic          trig_en,
    input  logic [DW-1:0] trig_level,
    input  logic [15:0]   holdoff,
    input  logic          read_busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_wr_data,
    output logic          read_start,
    output logic          acq_busy,
    output logic [15:0]   frame_cnt,
    output logic          timeout_err
);

    localparam logic [15:0]   KICK_LOAD = 16'(KICK_CYC - 1);
    localparam logic [15:0]   TO_LOAD   = 16'(TIMEOUT - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    acq_state_t    state, state_nx;
    logic          run_d;
    logic          run_rise;
    logic          start;
    logic          cont;
    logic [AW-1:0] wr_addr;
    logic [15:0]   cnt;
    logic          trig_hit;
    logic          accept;
    logic          last;
    logic          timeout_hit;
    logic          frame_done;

    assign run_rise = run && !run_d;
    assign start    = (state == ST_IDLE) && (single || run_rise);

    adc_trig_detect #(.DW(DW)) u_trig (
        .clk        (clk),
        .reset_n    (reset_n),
        .arm        (state == ST_ARM),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .trig_level (trig_level),
        .trig_hit   (trig_hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        last        = 1'b0;
        timeout_hit = 1'b0;
        frame_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nx = ST_ARM;
            end
            ST_ARM: begin
                accept = trig_en ? trig_hit : adc_valid;
                if (accept)
                    state_nx = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                accept = adc_valid;
                last   = adc_valid && (wr_addr == LAST_ADDR);
                if (last)
                    state_nx = ST_KICK;
            end
            ST_KICK: begin
                if (cnt == 16'd0)
                    state_nx = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (read_busy) begin
                    state_nx = ST_WAIT_DONE;
                end else if (cnt == 16'd0) begin
                    timeout_hit = 1'b1;
                    state_nx    = ST_HOLDOFF;
                end
            end
            ST_WAIT_DONE: begin
                if (!read_busy) begin
                    frame_done = 1'b1;
                    state_nx   = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                // holdoff of 0 or 1 both give one cycle here
                if (cnt <= 16'd1)
                    state_nx = (cont && run) ? ST_ARM : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Write port stage: address and data register with the accepting strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_we      <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            wr_addr     <= '0;
        end else begin
            ram_we <= accept;
            if (accept) begin
                ram_wr_addr <= wr_addr;
                ram_wr_data <= adc_data;
                wr_addr     <= last ? '0 : wr_addr + AW'(1);
            end
        end
    end

    // Shared down-counter: kick width, busy-rise timeout, hold-off
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 16'd0;
        end else if (state_nx != state) begin
            case (state_nx)
                ST_KICK:      cnt <= KICK_LOAD;
                ST_WAIT_RISE: cnt <= TO_LOAD;
                ST_HOLDOFF:   cnt <= holdoff;
                default:      cnt <= cnt;
            endcase
        end else if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_d       <= 1'b0;
            cont        <= 1'b0;
            read_start  <= 1'b0;
            acq_busy    <= 1'b0;
            frame_cnt   <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            run_d      <= run;
            read_start <= (state_nx == ST_KICK);
            acq_busy   <= (state_nx != ST_IDLE);
            if (start)
                cont <= run_rise;
            if (frame_done)
                frame_cnt <= frame_cnt + 16'd1;
            if (timeout_hit)
                timeout_err <= 1'b1;
            else if (single || run_rise)
                timeout_err <= 1'b0;
        end
    end

endmodule
